// File: rtl/wormy_arena.sv
// wormy_arena: parametrised snake-game core on a toroidal W x H arena.
// Keeps per-cell direction memory so the tail can follow the body path,
// places food through an LFSR-seeded linear search, and tracks score/growth.
module wormy_arena #(
  parameter int          GRID_W        = 8,
  parameter int          GRID_H        = 8,
  parameter int          UPDATE_RATE   = 300,
  parameter int          GROW_PER_FOOD = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       button_pushed,
  input  logic [1:0]                 button_state,
  output logic [GRID_W*GRID_H-1:0]   arena_on,
  output logic [GRID_W*GRID_H-1:0]   food_on,
  output logic [7:0]                 score,
  output logic [2:0]                 game_state
);

  localparam int N  = GRID_W * GRID_H;
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int IW = XW + YW;
  localparam int CW = $clog2(UPDATE_RATE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(UPDATE_RATE - 1);
  localparam logic [IW-1:0] PLACE_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PLACE = 3'd2,
    DEAD  = 3'd3,
    WIN   = 3'd4
  } state_t;

  state_t               state;
  logic [XW-1:0]        head_x, tail_x, hx_n, tx_n;
  logic [YW-1:0]        head_y, tail_y, hy_n, ty_n;
  logic [N-1:0][1:0]    dir_mem;
  logic [N-1:0]         arena_n;
  logic [7:0]           grow_cnt, grow_base, grow_n, score_n;
  logic [8:0]           grow_sum;
  logic [1:0]           pending_dir, head_dir, tail_dir;
  logic [CW-1:0]        cnt;
  logic                 step_pend;
  logic [15:0]          lfsr, lfsr_n;
  logic [IW-1:0]        place_idx, place_cnt;
  logic [IW-1:0]        head_idx, tail_idx, hn_idx;
  logic                 do_step, tail_moves, hit, eat, press_ok, place_free;

  assign game_state = state;

  // Next-step combinational datapath: head/tail moves, collision, food, growth.
  always_comb begin
    head_idx = {head_y, head_x};
    tail_idx = {tail_y, tail_x};
    head_dir = dir_mem[head_idx];
    tail_dir = dir_mem[tail_idx];
    lfsr_n   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    do_step  = (state == RUN) && (step_pend || (cnt == CNT_LAST));
    hx_n = head_x;
    hy_n = head_y;
    case (pending_dir)
      2'd0:    hy_n = head_y - 1'b1;
      2'd1:    hx_n = head_x + 1'b1;
      2'd2:    hy_n = head_y + 1'b1;
      default: hx_n = head_x - 1'b1;
    endcase
    tx_n = tail_x;
    ty_n = tail_y;
    case (tail_dir)
      2'd0:    ty_n = tail_y - 1'b1;
      2'd1:    tx_n = tail_x + 1'b1;
      2'd2:    ty_n = tail_y + 1'b1;
      default: tx_n = tail_x - 1'b1;
    endcase
    hn_idx     = {hy_n, hx_n};
    tail_moves = (grow_cnt == 8'd0);
    // Moving into the cell the tail is leaving this same step is legal.
    hit        = arena_on[hn_idx] && !((hn_idx == tail_idx) && tail_moves);
    eat        = food_on[hn_idx];
    arena_n    = arena_on;
    if (tail_moves) arena_n[tail_idx] = 1'b0;
    arena_n[hn_idx] = 1'b1;
    grow_base  = tail_moves ? 8'd0 : grow_cnt - 8'd1;
    grow_sum   = {1'b0, grow_base} + 9'(GROW_PER_FOOD);
    grow_n     = eat ? (grow_sum[8] ? 8'hFF : grow_sum[7:0]) : grow_base;
    score_n    = (score == 8'hFF) ? score : score + 8'd1;
    press_ok   = button_pushed && ((state == RUN) || (state == PLACE)) &&
                 (button_state != (head_dir ^ 2'b10));
    place_free = !arena_on[place_idx] && (place_idx != head_idx);
  end

  // Game FSM with all state, arena, food and score registers.
  always_ff @(posedge clk) begin
    if (rst || (start && ((state == DEAD) || (state == WIN)))) begin
      head_x           <= '0;
      head_y           <= '0;
      tail_x           <= '0;
      tail_y           <= YW'(1);
      dir_mem          <= '0;
      arena_on         <= '0;
      arena_on[0]      <= 1'b1;
      arena_on[GRID_W] <= 1'b1;
      food_on          <= '0;
      food_on[N-1]     <= 1'b1;
      score            <= '0;
      grow_cnt         <= '0;
      pending_dir      <= 2'd0;
      cnt              <= '0;
      step_pend        <= 1'b0;
      place_idx        <= '0;
      place_cnt        <= '0;
      if (rst) begin
        state <= IDLE;
        lfsr  <= LFSR_SEED;
      end else begin
        state <= RUN;
        lfsr  <= lfsr_n;
      end
    end else begin
      lfsr <= lfsr_n;
      if (press_ok) pending_dir <= button_state;
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (do_step) begin
            cnt       <= '0;
            step_pend <= 1'b0;
            if (hit) begin
              state <= DEAD;
            end else begin
              dir_mem[head_idx] <= pending_dir;
              dir_mem[hn_idx]   <= pending_dir;
              head_x            <= hx_n;
              head_y            <= hy_n;
              if (tail_moves) begin
                tail_x <= tx_n;
                tail_y <= ty_n;
              end
              arena_on <= arena_n;
              grow_cnt <= grow_n;
              if (eat) begin
                score     <= score_n;
                food_on   <= '0;
                place_idx <= lfsr[IW-1:0];
                place_cnt <= '0;
                state     <= PLACE;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLACE: begin
          // A step falling due while searching is deferred to the first RUN cycle.
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            step_pend <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (place_free) begin
            food_on[place_idx] <= 1'b1;
            state              <= RUN;
          end else begin
            place_idx <= place_idx + 1'b1;
            place_cnt <= place_cnt + 1'b1;
            if (place_cnt == PLACE_LAST) state <= WIN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
